shift32_seq_ctrl: RTL and testbench

//   Command sequencer placed directly upstream of the 32-bit 74LS194-style shift register.

---
 rtl/shift32_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_shift32_seq_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/shift32_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift32_seq_ctrl                                                 |
// | Purpose  : Load-then-shift command sequencer for a 32-bit 194-style shifter.|
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module shift32_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_dir,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic [1:0]       cmd_mode,
   input  logic [WIDTH-1:0] Q,
   output logic             S1,
   output logic             S0,
   output logic             SR,
   output logic             SL,
   output logic [WIDTH-1:0] PData,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] c_mode_zero  = 2'b00;
   localparam logic [1:0] c_mode_one   = 2'b01;
   localparam logic [1:0] c_mode_arith = 2'b10;
   localparam logic [1:0] c_mode_rot   = 2'b11;

   localparam logic [1:0] c_sel_hold  = 2'b00;
   localparam logic [1:0] c_sel_right = 2'b01;
   localparam logic [1:0] c_sel_left  = 2'b10;
   localparam logic [1:0] c_sel_load  = 2'b11;

   localparam logic [AMT_W-1:0] c_amt_one = AMT_W'(1);

   state_t           r_state;
   logic [1:0]       r_sel;
   logic [WIDTH-1:0] r_data;
   logic             r_dir;
   logic [AMT_W-1:0] r_amt;
   logic [1:0]       r_mode;
   logic [AMT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             w_fill;

   // Ready is gated by clear so it drops the moment the shared clear rises.
   assign cmd_ready = (r_state == ST_IDLE) && !clear;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_state <= ST_IDLE;
         r_sel   <= c_sel_hold;
         r_data  <= '0;
         r_dir   <= 1'b0;
         r_amt   <= '0;
         r_mode  <= c_mode_zero;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_data  <= cmd_data;
                  r_dir   <= cmd_dir;
                  r_amt   <= cmd_amt;
                  r_mode  <= cmd_mode;
                  r_cnt   <= cmd_amt;
                  r_busy  <= 1'b1;
                  r_sel   <= c_sel_load;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (r_amt == '0) begin
                  r_sel   <= c_sel_hold;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_sel   <= r_dir ? c_sel_right : c_sel_left;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // The edge that sees a count of one performs the final shift.
               if (r_cnt == c_amt_one) begin
                  r_sel   <= c_sel_hold;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt - c_amt_one;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_sel   <= c_sel_hold;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      w_fill = 1'b0;
      case (r_mode)
         c_mode_zero:  w_fill = 1'b0;
         c_mode_one:   w_fill = 1'b1;
         c_mode_arith: w_fill = r_dir ? Q[WIDTH-1] : 1'b0;
         c_mode_rot:   w_fill = r_dir ? Q[0] : Q[WIDTH-1];
         default:      w_fill = 1'b0;
      endcase
   end

   // Only the serial input on the active side carries the fill bit.
   assign SR    = r_dir ? w_fill : 1'b0;
   assign SL    = r_dir ? 1'b0 : w_fill;
   assign S1    = r_sel[1];
   assign S0    = r_sel[0];
   assign PData = r_data;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift32_seq_ctrl.sv
`default_nettype none
// Bench for shift32_seq_ctrl: drives commands into the sequencer attached to a
// 32-bit shift-register model and scores each done pulse against a queue.
module tb_shift32_seq_ctrl;

   logic        clk = 1'b0;
   logic        clear = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_data = '0;
   logic        cmd_dir = 1'b0;
   logic [4:0]  cmd_amt = '0;
   logic [1:0]  cmd_mode = '0;
   logic [31:0] q;
   logic        s1, s0, sr, sl;
   logic [31:0] pdata;
   logic        busy, done;

   int n_checks = 0;
   int n_err    = 0;
   int per      = 0;
   int n_load   = 0;
   int n_shift  = 0;

   typedef struct {
      logic [31:0] q;
      int          done_per;
      int          amt;
   } exp_t;
   exp_t sb[$];

   shift32_seq_ctrl #(.WIDTH(32), .AMT_W(5)) dut (
      .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_amt(cmd_amt), .cmd_mode(cmd_mode),
      .Q(q), .S1(s1), .S0(s0), .SR(sr), .SL(sl), .PData(pdata),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // 194-style register sharing clk and clear with the sequencer
   always_ff @(posedge clk or posedge clear) begin
      if (clear) q <= '0;
      else begin
         case ({s1, s0})
            2'b01:   q <= {sr, q[31:1]};
            2'b10:   q <= {q[30:0], sl};
            2'b11:   q <= pdata;
            default: q <= q;
         endcase
      end
   end

   always @(posedge clk) per <= per + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (period %0d)", name, act, exp, per);
      end
   endtask

   // Monitor: counts load/shift cycles and scores every done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (clear) begin
         n_load  = 0;
         n_shift = 0;
      end else begin
         if ({s1, s0} == 2'b11) n_load++;
         if ({s1, s0} == 2'b01 || {s1, s0} == 2'b10) n_shift++;
         if (done) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("result_q", q, e.q);
               chk("done_period", per, e.done_per);
               chk("load_cycles", n_load, 32'd1);
               chk("shift_cycles", n_shift, e.amt);
               chk("busy_at_done", {31'd0, busy}, 32'd1);
            end
            n_load  = 0;
            n_shift = 0;
         end
      end
   end

   task automatic send(input logic [31:0] data, input logic dir, input int amt,
                       input logic [1:0] mode, input logic [31:0] expq,
                       input bit keep, input bit score, output int acc_per);
      int k;
      @(negedge clk);
      cmd_data  = data;
      cmd_dir   = dir;
      cmd_amt   = 5'(amt);
      cmd_mode  = mode;
      cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
      acc_per = per;
      if (score) sb.push_back('{q: expq, done_per: per + amt + 2, amt: amt});
      @(posedge clk);
      #1;
      if (!keep) cmd_valid = 1'b0;
   endtask

   initial begin
      int a1, a2, a3;
      int k;
      #12;
      chk("rst_s1s0", {30'd0, s1, s0}, 32'd0);
      chk("rst_srsl", {30'd0, sr, sl}, 32'd0);
      chk("rst_pdata", pdata, 32'd0);
      chk("rst_busy_done_ready", {29'd0, busy, done, cmd_ready}, 32'd0);
      @(negedge clk);
      clear = 1'b0;
      #1;
      chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

      send(32'h12345678, 1'b0, 4,  2'b00, 32'h23456780, 1'b0, 1'b1, a1);
      send(32'h80000000, 1'b1, 31, 2'b10, 32'hFFFFFFFF, 1'b0, 1'b1, a1);
      send(32'h0000000F, 1'b1, 4,  2'b11, 32'hF0000000, 1'b0, 1'b1, a1);
      send(32'h0000000F, 1'b0, 4,  2'b11, 32'h000000F0, 1'b0, 1'b1, a1);
      send(32'hDEADBEEF, 1'b0, 0,  2'b00, 32'hDEADBEEF, 1'b0, 1'b1, a1);
      send(32'h40000000, 1'b1, 2,  2'b10, 32'h10000000, 1'b0, 1'b1, a1);

      // valid held high across back-to-back commands
      send(32'h00000000, 1'b0, 3,  2'b01, 32'h00000007, 1'b1, 1'b1, a1);
      send(32'h00000001, 1'b0, 1,  2'b00, 32'h00000002, 1'b0, 1'b1, a2);
      chk("hold_accept_period", a2, a1 + 3 + 2 + 1);

      // clear in cycle 5 of a 10-shift command
      send(32'hFFFF0000, 1'b1, 10, 2'b00, 32'h0, 1'b0, 1'b0, a3);
      repeat (5) @(negedge clk);
      clear = 1'b1;
      #1;
      chk("clr_busy", {31'd0, busy}, 32'd0);
      chk("clr_s1s0", {30'd0, s1, s0}, 32'd0);
      chk("clr_q", q, 32'd0);
      chk("clr_done_ready", {30'd0, done, cmd_ready}, 32'd0);
      @(negedge clk);
      clear = 1'b0;
      #1;
      chk("ready_after_clear", {31'd0, cmd_ready}, 32'd1);

      send(32'hA5A5A5A5, 1'b1, 2,  2'b01, 32'hE9696969, 1'b0, 1'b1, a1);

      k = 0;
      while (sb.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("scoreboard_drained", sb.size(), 32'd0);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
